// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package button_debouncer_pkg;

    // Debouncer FSM states, 2-bit encoding
    localparam logic [1:0] DB_IDLE         = 2'd0;  // released and stable
    localparam logic [1:0] DB_PRESS_WAIT   = 2'd1;  // qualifying a press
    localparam logic [1:0] DB_PRESSED      = 2'd2;  // pressed and stable
    localparam logic [1:0] DB_RELEASE_WAIT = 2'd3;  // qualifying a release

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchroniser that brings an asynchronous pin into the clock domain.
// Latency: 2 cycles from pin to q.
// Backpressure: none; free-running, reset clears both flops to 0.
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the pin through two flops; synchronous active-low clear
    always_ff @(posedge clock) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw push-button into a clean level plus press/release strobes.
// Latency: STABLE_CYCLES+2 edges with DEBOUNCE_SYNC_EN, STABLE_CYCLES edges without.
// Backpressure: none; strobes are single-cycle and must be consumed when high.
module button_debouncer #(
    parameter int STABLE_CYCLES = 250000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    import button_debouncer_pkg::*;

    // Counter holds the number of consecutive samples already seen at the
    // candidate level; acceptance happens on the STABLE_CYCLES-th sample.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             b_s;
    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             pressed_nx;
    logic             press_nx;
    logic             release_nx;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d     (button),
        .q     (b_s)
    );
`else
    // Direct sampling: only safe for stimulus already synchronous to clock
    assign b_s = button;
`endif

    // Next-state logic: qualify each level change for STABLE_CYCLES samples
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pressed_nx = pressed;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        case (state)
            DB_IDLE: begin
                if (b_s) begin
                    state_nx = DB_PRESS_WAIT;
                    cnt_nx   = CNT_ONE;
                end else begin
                    cnt_nx   = '0;
                end
            end
            DB_PRESS_WAIT: begin
                if (!b_s) begin
                    // any glitch restarts qualification from scratch
                    state_nx = DB_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx   = DB_PRESSED;
                    cnt_nx     = '0;
                    pressed_nx = 1'b1;
                    press_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            DB_PRESSED: begin
                if (!b_s) begin
                    state_nx = DB_RELEASE_WAIT;
                    cnt_nx   = CNT_ONE;
                end else begin
                    cnt_nx   = '0;
                end
            end
            DB_RELEASE_WAIT: begin
                if (b_s) begin
                    state_nx = DB_PRESSED;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx   = DB_IDLE;
                    cnt_nx     = '0;
                    pressed_nx = 1'b0;
                    release_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx = DB_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // State, counter and output registers; reset drops any pending strobe
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= DB_IDLE;
            cnt           <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            pressed       <= pressed_nx;
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
        end
    end

endmodule
